// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller:
// FSM encoding, stage indices and redirect vectors.
package pipe_ctrl_pkg;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EXE = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam logic [31:0] EXC_VEC_DEF = 32'hBFC00380;
    localparam logic [31:0] RST_VEC     = 32'hBFC00000;

    // An exception outranks a simultaneous ERET.
    function automatic logic [31:0] redir_target(
        input logic        is_exc,
        input logic [31:0] epc,
        input logic [31:0] vec
    );
        return is_exc ? vec : epc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline and its controller.
// master = controller side, slave = pipeline side.
interface pipe_ctrl_if #(
    parameter int NUM_STAGES = 6
) ();

    logic [NUM_STAGES-1:0] stall_req;
    logic                  mc_start;
    logic                  exc_valid;
    logic                  exc_eret;
    logic [31:0]           epc_in;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] flush;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  mc_busy;
    logic                  mc_done;

    modport master (
        input  stall_req, mc_start, exc_valid,
        input  exc_eret, epc_in,
        output stall, flush, redirect_valid,
        output redirect_pc, mc_busy, mc_done
    );

    modport slave (
        output stall_req, mc_start, exc_valid,
        output exc_eret, epc_in,
        input  stall, flush, redirect_valid,
        input  redirect_pc, mc_busy, mc_done
    );

endinterface

// File: rtl/pipe_mc_timer.sv
// Hold timer for multi-cycle EXE ops: busy for MC_LAT-1
// cycles after start, then a one-cycle done pulse.
module pipe_mc_timer #(
    parameter int MC_LAT = 32,
    parameter int CNT_W  = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(MC_LAT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start && cnt == '0) begin
            cnt  <= LOAD;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (cnt != '0) begin
            cnt  <= cnt - CNT_W'(1);
            busy <= (cnt != CNT_W'(1));
            done <= (cnt == CNT_W'(1));
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller for the 5-stage pipeline.
// Define PIPE_CTRL_PERF_EN to add stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          NUM_STAGES = 6,
    parameter int          MC_STAGE   = STG_EXE,
    parameter int          MC_LAT     = 32,
    parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
    parameter int          CNT_W      = 6
) (
    input  logic         clk,
    input  logic         reset,
    pipe_ctrl_if.master  bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]  perf_stall_cycles,
    output logic [31:0]  perf_flushes
`endif
);

    logic [0:0]            state;
    logic                  take;
    logic [NUM_STAGES-1:0] stall_v;
    logic [NUM_STAGES-1:0] flush_q;
    logic                  rv_q;
    logic [31:0]           rpc_q;
    logic                  acc;

    assign take = (state == RUN) &&
                  (bus.exc_valid || bus.exc_eret);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= RUN;
            flush_q <= '0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
        end else if (take) begin
            state   <= FLUSH;
            flush_q <= '1;
            rv_q    <= 1'b1;
            rpc_q   <= redir_target(bus.exc_valid,
                                    bus.epc_in, EXC_VEC);
        end else begin
            state   <= RUN;
            flush_q <= '0;
            rv_q    <= 1'b0;
        end
    end

    pipe_mc_timer #(
        .MC_LAT (MC_LAT),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (take),
        .start (bus.mc_start && state == RUN),
        .busy  (bus.mc_busy),
        .done  (bus.mc_done)
    );

    // A request at stage k holds every older stage 0..k.
    always_comb begin
        stall_v = '0;
        acc     = 1'b0;
        if (reset && state == RUN) begin
            for (int i = NUM_STAGES - 1; i >= 0; i--) begin
                acc        = acc | bus.stall_req[i];
                stall_v[i] = acc |
                             (bus.mc_busy && i <= MC_STAGE);
            end
        end
    end

    assign bus.stall          = stall_v;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = rpc_q;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (stall_v[0] && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (take && perf_flushes != '1)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MC_LAT=4).
// Perf counter checks compile in with PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

    localparam logic [31:0] EXC = 32'hBFC00380;
    localparam logic [31:0] EPC = 32'hBFC01234;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;
`endif

    pipe_ctrl_if #(.NUM_STAGES(6)) bus ();

    pipe_ctrl #(
        .NUM_STAGES (6),
        .MC_STAGE   (3),
        .MC_LAT     (4),
        .EXC_VEC    (EXC),
        .CNT_W      (6)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall_req = '0;
        bus.mc_start  = 1'b0;
        bus.exc_valid = 1'b0;
        bus.exc_eret  = 1'b0;
        bus.epc_in    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        bus.stall_req = 6'b111111;
        tick();
        tick();
        #1;
        tests++;
        if (bus.stall !== 6'b0) begin
            fails++;
            $display("FAIL rst_stall: got %b want 000000",
                     bus.stall);
        end
        tests++;
        if (bus.flush !== 6'b0 || bus.redirect_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_flush: got %b/%b want 000000/0",
                     bus.flush, bus.redirect_valid);
        end
        tests++;
        if (bus.redirect_pc !== 32'h0) begin
            fails++;
            $display("FAIL rst_pc: got %h want 00000000",
                     bus.redirect_pc);
        end
        tests++;
        if (bus.mc_busy !== 1'b0 || bus.mc_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_mc: got %b%b want 00",
                     bus.mc_busy, bus.mc_done);
        end
        bus.stall_req = '0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        logic [5:0] req [4];
        logic [5:0] exp [4];
        req = '{6'b000100, 6'b010000, 6'b000001, 6'b100000};
        exp = '{6'b000111, 6'b011111, 6'b000001, 6'b111111};
        for (int k = 0; k < 4; k++) begin
            bus.stall_req = req[k];
            #1;
            tests++;
            if (bus.stall !== exp[k] || bus.flush !== 6'b0) begin
                fails++;
                $display("FAIL lu_stall%0d: got %b/%b want %b/000000",
                         k, bus.stall, bus.flush, exp[k]);
            end
            tick();
            bus.stall_req = '0;
            #1;
            tests++;
            if (bus.stall !== 6'b0) begin
                fails++;
                $display("FAIL lu_release%0d: got %b want 000000",
                         k, bus.stall);
            end
        end
    endtask

    task automatic test_multicycle();
        bus.mc_start = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            // re-issue in the middle cycle must be ignored
            bus.mc_start = (c == 1);
            #1;
            tests++;
            if (bus.mc_busy !== 1'b1 || bus.mc_done !== 1'b0 ||
                bus.stall !== 6'b001111) begin
                fails++;
                $display("FAIL mc_busy%0d: got %b%b %b want 10 001111",
                         c, bus.mc_busy, bus.mc_done, bus.stall);
            end
            tick();
        end
        bus.mc_start = 1'b0;
        #1;
        tests++;
        if (bus.mc_busy !== 1'b0 || bus.mc_done !== 1'b1 ||
            bus.stall !== 6'b0) begin
            fails++;
            $display("FAIL mc_done: got %b%b %b want 01 000000",
                     bus.mc_busy, bus.mc_done, bus.stall);
        end
        tick();
        tests++;
        if (bus.mc_done !== 1'b0 || bus.mc_busy !== 1'b0) begin
            fails++;
            $display("FAIL mc_pulse: got %b%b want 00",
                     bus.mc_busy, bus.mc_done);
        end
    endtask

    task automatic test_exc_during_mc();
        bus.mc_start = 1'b1;
        tick();
        bus.mc_start = 1'b0;
        tick();
        bus.exc_valid = 1'b1;
        #1;
        tests++;
        if (bus.stall !== 6'b001111 || bus.flush !== 6'b0) begin
            fails++;
            $display("FAIL exc_pre: got %b/%b want 001111/000000",
                     bus.stall, bus.flush);
        end
        tick();
        // new events arriving in FLUSH must be ignored
        bus.stall_req = 6'b111111;
        bus.mc_start  = 1'b1;
        #1;
        tests++;
        if (bus.flush !== 6'b111111 || bus.redirect_valid !== 1'b1 ||
            bus.redirect_pc !== EXC) begin
            fails++;
            $display("FAIL exc_flush: got %b %b %h want 111111 1 %h",
                     bus.flush, bus.redirect_valid,
                     bus.redirect_pc, EXC);
        end
        tests++;
        if (bus.mc_busy !== 1'b0 || bus.mc_done !== 1'b0 ||
            bus.stall !== 6'b0) begin
            fails++;
            $display("FAIL exc_mc: got %b%b %b want 00 000000",
                     bus.mc_busy, bus.mc_done, bus.stall);
        end
        tick();
        idle_inputs();
        #1;
        tests++;
        if (bus.flush !== 6'b0 || bus.redirect_valid !== 1'b0 ||
            bus.mc_busy !== 1'b0 || bus.mc_done !== 1'b0) begin
            fails++;
            $display("FAIL exc_after: got %b %b %b%b want 000000 0 00",
                     bus.flush, bus.redirect_valid,
                     bus.mc_busy, bus.mc_done);
        end
        tick();
        tests++;
        if (bus.mc_done !== 1'b0 || bus.mc_busy !== 1'b0) begin
            fails++;
            $display("FAIL exc_nodone: got %b%b want 00",
                     bus.mc_busy, bus.mc_done);
        end
    endtask

    task automatic test_eret();
        bus.epc_in   = EPC;
        bus.exc_eret = 1'b1;
        tick();
        idle_inputs();
        #1;
        tests++;
        if (bus.redirect_pc !== EPC || bus.redirect_valid !== 1'b1 ||
            bus.flush !== 6'b111111) begin
            fails++;
            $display("FAIL eret: got %h %b %b want %h 1 111111",
                     bus.redirect_pc, bus.redirect_valid,
                     bus.flush, EPC);
        end
        tick();
        bus.epc_in    = EPC;
        bus.exc_eret  = 1'b1;
        bus.exc_valid = 1'b1;
        tick();
        idle_inputs();
        #1;
        tests++;
        if (bus.redirect_pc !== EXC || bus.redirect_valid !== 1'b1) begin
            fails++;
            $display("FAIL eret_vs_exc: got %h %b want %h 1",
                     bus.redirect_pc, bus.redirect_valid, EXC);
        end
        tick();
        bus.exc_valid = 1'b1;
        bus.mc_start  = 1'b1;
        tick();
        idle_inputs();
        #1;
        tests++;
        if (bus.flush !== 6'b111111 || bus.mc_busy !== 1'b0) begin
            fails++;
            $display("FAIL exc_vs_start: got %b %b want 111111 0",
                     bus.flush, bus.mc_busy);
        end
        tick();
        tests++;
        if (bus.mc_busy !== 1'b0 || bus.stall !== 6'b0) begin
            fails++;
            $display("FAIL exc_vs_start2: got %b %b want 0 000000",
                     bus.mc_busy, bus.stall);
        end
    endtask

    task automatic test_reset_mid_flush();
        bus.exc_valid = 1'b1;
        tick();
        bus.exc_valid = 1'b0;
        reset = 1'b0;
        #1;
        tests++;
        if (bus.flush !== 6'b111111) begin
            fails++;
            $display("FAIL rmf_enter: got %b want 111111", bus.flush);
        end
        tick();
        tests++;
        if (bus.flush !== 6'b0 || bus.redirect_valid !== 1'b0 ||
            bus.redirect_pc !== 32'h0 || bus.stall !== 6'b0) begin
            fails++;
            $display("FAIL rmf_clear: got %b %b %h %b want all zero",
                     bus.flush, bus.redirect_valid,
                     bus.redirect_pc, bus.stall);
        end
        reset = 1'b1;
        bus.exc_valid = 1'b1;
        tick();
        bus.exc_valid = 1'b0;
        #1;
        tests++;
        if (bus.flush !== 6'b111111 || bus.redirect_valid !== 1'b1 ||
            bus.redirect_pc !== EXC) begin
            fails++;
            $display("FAIL rmf_new_exc: got %b %b %h want 111111 1 %h",
                     bus.flush, bus.redirect_valid,
                     bus.redirect_pc, EXC);
        end
        tick();
        bus.mc_start = 1'b1;
        tick();
        bus.mc_start = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        tests++;
        if (bus.mc_busy !== 1'b0 || bus.mc_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_timer: got %b%b want 00",
                     bus.mc_busy, bus.mc_done);
        end
        tick();
        tick();
        tests++;
        if (bus.mc_busy !== 1'b0 || bus.mc_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_timer_quiet: got %b%b want 00",
                     bus.mc_busy, bus.mc_done);
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.stall_req = 6'b000001;
        repeat (10) tick();
        bus.stall_req = '0;
        for (int n = 0; n < 2; n++) begin
            bus.exc_valid = 1'b1;
            tick();
            bus.exc_valid = 1'b0;
            tick();
        end
        #1;
        tests++;
        if (perf_stall_cycles !== 32'd10) begin
            fails++;
            $display("FAIL perf_stall: got %0d want 10",
                     perf_stall_cycles);
        end
        tests++;
        if (perf_flushes !== 32'd2) begin
            fails++;
            $display("FAIL perf_flush: got %0d want 2",
                     perf_flushes);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_multicycle();
        test_exc_during_mc();
        test_eret();
        test_reset_mid_flush();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush/redirect controller for the 5-stage MIPS pipeline.
- Replaces the externally driven fixed 6-bit `stall` vector. It generates `stall` from per-stage requests, an internal multi-cycle-op hold timer (MUL/DIV in EXE), and exception/ERET flushes.
- Parametrised in stage count, multi-cycle stage index, latency and vectors, so PC, IF_ID, ID_EXE, EXE_MEM and MEM_WB consume `stall`/`flush` unchanged.

Parameters:
- NUM_STAGES, 6, number of stall/flush bits (bit 0 = PC, ascending toward WB).
- MC_STAGE, 3, stage index holding the multi-cycle op (EXE).
- MC_LAT, 32, multi-cycle op latency in cycles (>=2).
- EXC_VEC, 32'hBFC00380, general exception entry PC.
- CNT_W, 6, width of the hold counter (must hold MC_LAT).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- stall_req  in  NUM_STAGES  per-stage hold request (e.g. ID load-use, MEM wait).
- mc_start  in  1  pulse: EXE issued a multi-cycle op this cycle.
- exc_valid  in  1  MEM/WB commit-point exception.
- exc_eret  in  1  ERET committing.
- epc_in  in  32  CP0 EPC, used for ERET.
- stall  out  NUM_STAGES  hold vector to pipeline registers.
- flush  out  NUM_STAGES  clear-to-bubble vector.
- redirect_valid  out  1  PC must load redirect_pc.
- redirect_pc  out  32  redirect target.
- mc_busy  out  1  hold timer active.
- mc_done  out  1  one-cycle pulse: multi-cycle result valid.

Behaviour:
- Reset (reset==0 at posedge): state=RUN, counter=0. All registered outputs are 0: flush, redirect_valid, redirect_pc=0, mc_busy, mc_done. stall is forced to 0 while reset is low.
- FSM states are RUN and FLUSH.
- **RUN stall, combinational:** stall[i] = OR of stall_req[j] for j>=i, OR (mc_busy && i<=MC_STAGE).
  - A request at stage k holds stages 0..k. Stage k+1 sees stall=0 and the hold register inserts the bubble.
- **Multi-cycle timer:** mc_start in RUN with counter==0 loads counter=MC_LAT-1 and sets mc_busy=1 on the next edge.
  - The counter decrements each cycle.
  - When the counter goes 1->0, mc_busy drops and mc_done pulses for exactly one cycle.
  - mc_start while busy is ignored.
- **Exception:** exc_valid in RUN moves the FSM to FLUSH at the next edge. While in FLUSH (exactly 1 cycle):
  - flush = all ones;
  - stall = 0;
  - redirect_valid = 1;
  - redirect_pc = EXC_VEC.
  - The counter is cleared and mc_busy/mc_done are forced to 0; an in-flight op is abandoned.
- **ERET:** exc_eret in RUN behaves the same as an exception, except redirect_pc = epc_in, captured on the transition edge.
- Simultaneous exc_valid and exc_eret: exception wins, target is EXC_VEC.
- exc_valid, exc_eret and mc_start arriving while in FLUSH are ignored. FLUSH always returns to RUN.
- Exception in the same cycle as mc_start: exception wins and the timer is not loaded.
- Flush has priority over stall in every stage.
- Latency: request-to-stall is 0 cycles; exception-to-flush/redirect is 1 cycle.
- reset low mid-FLUSH or mid-timer: everything returns to reset values on that edge.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, adds outputs perf_stall_cycles[31:0] and perf_flushes[31:0].
  - perf_stall_cycles increments on every cycle with stall[0]==1.
  - perf_flushes increments on every entry into FLUSH.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package or global define header holds:
  - FSM state encoding (RUN=1'b0, FLUSH=1'b1);
  - stage index constants (STG_PC=0, STG_IF=1, STG_ID=2, STG_EXE=3, STG_MEM=4, STG_WB=5);
  - EXC_VEC and reset vector constants.
- One sub-module: pipe_mc_timer (load/decrement counter producing mc_busy and mc_done).

Test Plan:
- **Load-use stall:** stall_req=6'b000100 for 1 cycle -> stall=6'b000111 the same cycle, flush=0, then stall=0.
- **Multi-cycle op:** mc_start pulse with MC_LAT=4 -> mc_busy high 3 cycles, stall=6'b001111 during them, then mc_done high 1 cycle.
- **Exception during multi-cycle hold:** exc_valid in 2nd busy cycle -> next cycle flush=6'b111111, redirect_valid=1, redirect_pc=32'hBFC00380, mc_busy=0, no mc_done pulse.
- **ERET vs exception:** exc_eret with epc_in=32'hBFC01234 -> redirect_pc=32'hBFC01234. exc_eret and exc_valid together -> redirect_pc=32'hBFC00380.
- **Reset mid-FLUSH:** reset low in the FLUSH cycle -> next edge all outputs 0 and state RUN. A new exc_valid is accepted after reset deasserts.
- **PERF (PIPE_CTRL_PERF_EN):** 10 stalled cycles and 2 flushes -> perf_stall_cycles=10, perf_flushes=2.
